mux_frame_mapper: RTL and testbench

Parametrised, multi-channel successor to the single-client sender mapper. It byte-interleaves NUM_CH client AXIS payload streams into a fixed NUM_ROWS x NUM_COLS byte frame and builds the overhead in-line: FAS, optional multiframe counter, CRC-8 of the previous frame's payload, and a per-channel fill bitmap. The byte stream it emits feeds the line FIFO / serial transmitter. Starved channels receive fill bytes so that one idle client does not stall the frame.

---
 rtl/mux_frame_mapper.sv | 192 +++++++++++++++++++
 tb/tb_mux_frame_mapper.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/mux_frame_mapper.sv
// mux_frame_mapper: byte-interleaves NUM_CH AXIS clients into a NUM_ROWS x NUM_COLS frame with
// in-line FAS / MFAS / CRC-8 / fill-bitmap overhead. Define MUX_MAP_MFAS_EN for the multiframe counter.

module mux_frame_lane #(
  parameter logic [7:0] FILL_BYTE = 8'h00
) (
  input  logic       sel,
  input  logic       load,
  input  logic       vld,
  input  logic [7:0] data,
  output logic       req,
  output logic       fill,
  output logic [7:0] byte_o
);
  // A starved slot is padded instead of stalling the frame; req stays low-impact since vld is low.
  always_comb begin
    req    = load & sel;
    fill   = sel & ~vld;
    byte_o = 8'h00;
    if (sel) byte_o = vld ? data : FILL_BYTE;
  end
endmodule

module mux_frame_mapper #(
  parameter int         NUM_CH    = 2,
  parameter int         NUM_ROWS  = 4,
  parameter int         NUM_COLS  = 1040,
  parameter int         OH_COLS   = 16,
  parameter int         FAS_LEN   = 6,
  parameter logic [7:0] FILL_BYTE = 8'h00
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic [8*NUM_CH-1:0]   i_pyld_data,
  input  logic [NUM_CH-1:0]     i_pyld_data_valid,
  output logic [NUM_CH-1:0]     o_pyld_data_req,
  input  logic                  i_hold,
  output logic [7:0]            o_frame_data,
  output logic                  o_frame_data_valid,
  output logic                  o_frame_data_fas,
  input  logic                  i_line_ready,
  output logic [7:0]            o_crc_val,
  output logic                  o_frame_done
);
  localparam int CW = (NUM_COLS > 1) ? $clog2(NUM_COLS) : 1;
  localparam int RW = (NUM_ROWS > 1) ? $clog2(NUM_ROWS) : 1;
  localparam int HW = (NUM_CH   > 1) ? $clog2(NUM_CH)   : 1;

  logic [CW-1:0]     col_q, col_d;
  logic [RW-1:0]     row_q, row_d;
  logic [HW-1:0]     ch_q, ch_d;
  logic [7:0]        crc_q, crc_d, crc_st_q, crc_st_d, crc_nxt;
  logic [NUM_CH-1:0] fill_q, fill_d, fill_st_q, fill_st_d, fill_nxt;
  logic [7:0]        data_q, data_d;
  logic              vld_q, vld_d, fas_q, fas_d;

  logic              load, col_last, row_last, frame_last, is_pyld;
  logic [NUM_CH-1:0] sel, lane_req, lane_fill;
  logic [NUM_CH-1:0][7:0] lane_byte;
  logic [7:0]        pyld_byte, oh_byte, mfas;

  function automatic logic [7:0] crc8_upd(input logic [7:0] c, input logic [7:0] b);
    logic [7:0] r;
    r = c ^ b;
    for (int i = 0; i < 8; i++) r = r[7] ? ({r[6:0], 1'b0} ^ 8'h07) : {r[6:0], 1'b0};
    return r;
  endfunction

  assign load       = ~i_hold & (~vld_q | i_line_ready);
  assign col_last   = (col_q == CW'(NUM_COLS - 1));
  assign row_last   = (row_q == RW'(NUM_ROWS - 1));
  assign frame_last = col_last & row_last;
  assign is_pyld    = (col_q >= CW'(OH_COLS));

  // ch_q tracks (col-OH_COLS) mod NUM_CH incrementally so no divider is needed.
  for (genvar g = 0; g < NUM_CH; g++) begin : g_lane
    assign sel[g] = is_pyld & (ch_q == HW'(g));
    mux_frame_lane #(.FILL_BYTE(FILL_BYTE)) u_lane (
      .sel    (sel[g]),
      .load   (load),
      .vld    (i_pyld_data_valid[g]),
      .data   (i_pyld_data[8*g +: 8]),
      .req    (lane_req[g]),
      .fill   (lane_fill[g]),
      .byte_o (lane_byte[g])
    );
  end

  always_comb begin
    pyld_byte = 8'h00;
    for (int i = 0; i < NUM_CH; i++) pyld_byte = pyld_byte | lane_byte[i];
  end

`ifdef MUX_MAP_MFAS_EN
  logic [7:0] mfas_q, mfas_d;
  always_comb begin
    mfas_d = mfas_q;
    if (load & frame_last) mfas_d = mfas_q + 8'd1;
  end
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) mfas_q <= 8'h00;
    else          mfas_q <= mfas_d;
  end
  assign mfas = mfas_q;
`else
  assign mfas = 8'h00;
`endif

  always_comb begin
    oh_byte = 8'h00;
    if (row_q == '0) begin
      if (col_q < CW'(FAS_LEN / 2))       oh_byte = 8'hF6;
      else if (col_q < CW'(FAS_LEN))      oh_byte = 8'h28;
      else if (col_q == CW'(FAS_LEN))     oh_byte = mfas;
      else if (col_q == CW'(FAS_LEN + 1)) oh_byte = crc_st_q;
      else if (col_q == CW'(FAS_LEN + 2)) oh_byte = 8'(fill_st_q);
    end
  end

  always_comb begin
    col_d     = col_q;
    row_d     = row_q;
    ch_d      = ch_q;
    crc_d     = crc_q;
    fill_d    = fill_q;
    crc_st_d  = crc_st_q;
    fill_st_d = fill_st_q;
    data_d    = data_q;
    vld_d     = vld_q;
    fas_d     = fas_q;
    crc_nxt   = is_pyld ? crc8_upd(crc_q, pyld_byte) : crc_q;
    fill_nxt  = fill_q | lane_fill;
    if (load) begin
      data_d = is_pyld ? pyld_byte : oh_byte;
      vld_d  = 1'b1;
      fas_d  = (row_q == '0) && (col_q == '0);
      crc_d  = crc_nxt;
      fill_d = fill_nxt;
      if (is_pyld) ch_d = (ch_q == HW'(NUM_CH - 1)) ? '0 : ch_q + 1'b1;
      if (col_last) begin
        col_d = '0;
        ch_d  = '0;
        row_d = row_last ? '0 : row_q + 1'b1;
      end else begin
        col_d = col_q + 1'b1;
      end
      // Frame boundary: publish CRC/bitmap for the next frame's overhead, restart accumulation.
      if (frame_last) begin
        crc_st_d  = crc_nxt;
        fill_st_d = fill_nxt;
        crc_d     = 8'h00;
        fill_d    = '0;
      end
    end else if (i_line_ready) begin
      vld_d = 1'b0;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      col_q     <= '0;
      row_q     <= '0;
      ch_q      <= '0;
      crc_q     <= 8'h00;
      fill_q    <= '0;
      crc_st_q  <= 8'h00;
      fill_st_q <= '0;
      data_q    <= 8'h00;
      vld_q     <= 1'b0;
      fas_q     <= 1'b0;
    end else begin
      col_q     <= col_d;
      row_q     <= row_d;
      ch_q      <= ch_d;
      crc_q     <= crc_d;
      fill_q    <= fill_d;
      crc_st_q  <= crc_st_d;
      fill_st_q <= fill_st_d;
      data_q    <= data_d;
      vld_q     <= vld_d;
      fas_q     <= fas_d;
    end
  end

  assign o_pyld_data_req    = lane_req;
  assign o_frame_data       = data_q;
  assign o_frame_data_valid = vld_q;
  assign o_frame_data_fas   = fas_q;
  assign o_crc_val          = crc_st_q;
  assign o_frame_done       = load & frame_last;

endmodule

// File: tb/tb_mux_frame_mapper.sv
// tb_mux_frame_mapper: directed + randomized checks of mux_frame_mapper against a
// position-based frame model (layout, fill, backpressure, hold, MFAS, mid-frame reset).
module tb_mux_frame_mapper;
  localparam int NC = 2, NR = 2, NCOL = 13, OH = 5, FL = 2;
  localparam logic [7:0] FILL = 8'h00;

  logic            i_clk = 1'b0, i_rst_n = 1'b1;
  logic [8*NC-1:0] i_pyld_data = '0;
  logic [NC-1:0]   i_pyld_data_valid = '0;
  logic [NC-1:0]   o_pyld_data_req;
  logic            i_hold = 1'b0, i_line_ready = 1'b0;
  logic [7:0]      o_frame_data, o_crc_val;
  logic            o_frame_data_valid, o_frame_data_fas, o_frame_done;

  int total = 0, bad = 0;

  mux_frame_mapper #(.NUM_CH(NC), .NUM_ROWS(NR), .NUM_COLS(NCOL), .OH_COLS(OH),
                     .FAS_LEN(FL), .FILL_BYTE(FILL)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_pyld_data(i_pyld_data),
    .i_pyld_data_valid(i_pyld_data_valid), .o_pyld_data_req(o_pyld_data_req),
    .i_hold(i_hold), .o_frame_data(o_frame_data), .o_frame_data_valid(o_frame_data_valid),
    .o_frame_data_fas(o_frame_data_fas), .i_line_ready(i_line_ready),
    .o_crc_val(o_crc_val), .o_frame_done(o_frame_done));

  always #5 i_clk = ~i_clk;

  // Reference model state: frame position plus per-frame payload record
  int         m_row, m_col, m_frames;
  logic [7:0] m_pay[$];
  logic [7:0] m_fill, m_crc_st, m_fill_st;
  logic [7:0] e_data;
  logic       e_vld, e_fas;
  int         cnt[NC];
  bit         rnd_data = 1'b0;
  logic [7:0] acc[$];

  logic [7:0] lay [26] = '{8'hF6, 8'h28, 8'h00, 8'h00, 8'h00, 8'h10, 8'h20, 8'h11, 8'h21,
                           8'h12, 8'h22, 8'h13, 8'h23,
                           8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h14, 8'h24, 8'h15, 8'h25,
                           8'h16, 8'h26, 8'h17, 8'h27};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] crc_step(input logic [7:0] c, input logic [7:0] b);
    logic [7:0] r;
    r = c ^ b;
    for (int k = 0; k < 8; k++) r = r[7] ? ({r[6:0], 1'b0} ^ 8'h07) : {r[6:0], 1'b0};
    return r;
  endfunction

  function automatic logic [7:0] crc_frame();
    logic [7:0] c;
    c = 8'h00;
    foreach (m_pay[k]) c = crc_step(c, m_pay[k]);
    return c;
  endfunction

  function automatic logic [7:0] exp_byte(input logic [NC-1:0] v);
    int ch;
    if (m_col >= OH) begin
      ch = (m_col - OH) % NC;
      return v[ch] ? i_pyld_data[8*ch +: 8] : FILL;
    end
    if (m_row != 0)     return 8'h00;
    if (m_col < FL / 2) return 8'hF6;
    if (m_col < FL)     return 8'h28;
`ifdef MUX_MAP_MFAS_EN
    if (m_col == FL)    return 8'(m_frames % 256);
`else
    if (m_col == FL)    return 8'h00;
`endif
    if (m_col == FL + 1) return m_crc_st;
    if (m_col == FL + 2) return m_fill_st;
    return 8'h00;
  endfunction

  task automatic m_reset();
    m_row = 0; m_col = 0; m_frames = 0;
    m_pay.delete();
    m_fill = 8'h00; m_crc_st = 8'h00; m_fill_st = 8'h00;
    e_data = 8'h00; e_vld = 1'b0; e_fas = 1'b0;
    for (int k = 0; k < NC; k++) cnt[k] = 0;
  endtask

  task automatic pulse_reset();
    i_rst_n = 1'b0;
    #1;
    chk("rst_data",  32'(o_frame_data), 32'h0);
    chk("rst_valid", 32'(o_frame_data_valid), 32'h0);
    chk("rst_fas",   32'(o_frame_data_fas), 32'h0);
    chk("rst_crc",   32'(o_crc_val), 32'h0);
    chk("rst_req",   32'(o_pyld_data_req), 32'h0);
    chk("rst_done",  32'(o_frame_done), 32'h0);
    m_reset();
    @(negedge i_clk);
    i_rst_n = 1'b1;
  endtask

  // One clock: drive at negedge, check combinational outputs, predict, check registered outputs.
  task automatic cyc(input bit hold, input bit rdy, input logic [NC-1:0] v);
    logic       ld, last;
    logic [NC-1:0] ereq;
    logic [7:0] b;
    int         ch;
    i_hold = hold; i_line_ready = rdy; i_pyld_data_valid = v;
    for (int k = 0; k < NC; k++)
      i_pyld_data[8*k +: 8] = rnd_data ? 8'($urandom) : 8'(8'h10 * (k + 1) + cnt[k]);
    #1;
    ld   = !hold && (!e_vld || rdy);
    last = (m_row == NR - 1) && (m_col == NCOL - 1);
    ereq = '0;
    if (ld && m_col >= OH) ereq[(m_col - OH) % NC] = 1'b1;
    chk("req",  32'(o_pyld_data_req), 32'(ereq));
    chk("done", 32'(o_frame_done), 32'(ld && last));
    if (e_vld && rdy) acc.push_back(o_frame_data);
    if (ld) begin
      b = exp_byte(v);
      if (m_col >= OH) begin
        ch = (m_col - OH) % NC;
        m_pay.push_back(b);
        if (v[ch]) cnt[ch]++;
        else       m_fill[ch] = 1'b1;
      end
      e_data = b; e_vld = 1'b1; e_fas = (m_row == 0) && (m_col == 0);
      if (last) begin
        m_crc_st = crc_frame(); m_fill_st = m_fill; m_fill = 8'h00;
        m_pay.delete(); m_frames++;
      end
      if (m_col == NCOL - 1) begin
        m_col = 0; m_row = (m_row == NR - 1) ? 0 : m_row + 1;
      end else m_col++;
    end else if (rdy) e_vld = 1'b0;
    @(posedge i_clk);
    #1;
    chk("valid", 32'(o_frame_data_valid), 32'(e_vld));
    chk("data",  32'(o_frame_data), 32'(e_data));
    chk("fas",   32'(o_frame_data_fas), 32'(e_fas));
    chk("crc",   32'(o_crc_val), 32'(m_crc_st));
    @(negedge i_clk);
  endtask

  initial begin
    logic [7:0] cref;
    int n;
    m_reset();
    #1;
    pulse_reset();

    // Layout: both channels always valid, no backpressure
    acc.delete();
    for (int i = 0; i < 27; i++) cyc(1'b0, 1'b1, '1);
    for (int i = 0; i < 26; i++) chk($sformatf("layout%0d", i), 32'(acc[i]), 32'(lay[i]));

    // Fill: ch1 starved for a whole frame
    pulse_reset();
    acc.delete();
    for (int i = 0; i < 26; i++) cyc(1'b0, 1'b1, 2'b01);
    for (int i = 0; i < 6; i++)  cyc(1'b0, 1'b1, '1);
    chk("fill_bmp", 32'(acc[26 + FL + 2]), 32'h02);
    cref = 8'h00;
    for (int i = 0; i < 8; i++) begin
      cref = crc_step(cref, 8'(8'h10 + i));
      cref = crc_step(cref, 8'h00);
    end
    chk("fill_crc", 32'(o_crc_val), 32'(cref));

    // Backpressure: ready 1,1,0,0,... must reproduce the layout byte sequence
    pulse_reset();
    acc.delete();
    for (int i = 0; i < 64; i++) cyc(1'b0, (i % 4) < 2, '1);
    for (int i = 0; i < 26; i++) chk($sformatf("bp%0d", i), 32'(acc[i]), 32'(lay[i]));

    // Hold: 5-cycle pause at row 1, col 7
    n = 0;
    while (!(m_row == 1 && m_col == 7) && n < 200) begin cyc(1'b0, 1'b1, '1); n++; end
    chk("hold_reach", 32'(n < 200), 32'h1);
    for (int i = 0; i < 5; i++) cyc(1'b1, 1'($urandom_range(0, 1)), '1);
    for (int i = 0; i < 20; i++) cyc(1'b0, 1'b1, '1);

    // Randomized hold / ready / valid / data
    rnd_data = 1'b1;
    for (int i = 0; i < 800; i++)
      cyc($urandom_range(0, 4) == 0, $urandom_range(0, 3) != 0, NC'($urandom));

    // MFAS: 257 frames from reset, then a mid-row reset
    pulse_reset();
    n = 0;
    while (m_frames < 257 && n < 8000) begin cyc(1'b0, 1'b1, NC'($urandom)); n++; end
    chk("mfas_run", 32'(n < 8000), 32'h1);
    n = 0;
    while (m_col != 6 && n < 50) begin cyc(1'b0, 1'b1, '1); n++; end
    pulse_reset();
    acc.delete();
    for (int i = 0; i < 6; i++) cyc(1'b0, 1'b1, '1);
    chk("post_rst_fas_byte", 32'(acc[0]), 32'hF6);
    chk("post_rst_mfas",     32'(acc[FL]), 32'h00);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
